dart_game_ctrl: RTL and testbench
=================================

# dart_game_ctrl

Two-player countdown game sequencer for the dart machine. Accepts one scored dart at a time from the upstream scoring datapath, charges it to the active player, and applies turn, bust and win rules. Drives the per-player point, turn-done, win and game-set status consumed by the display and test pattern side.

## Interface
- START_PT, 301: points loaded for each player on new game; must be ≤ 511.
- DARTS_PER_TURN, 3: darts per turn, 1..7.
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low reset.
- new_game_i  in  1  one-cycle strobe; starts or restarts a game.
- dart_come_i  in  1  one-cycle strobe; one dart per high cycle.
- dart_score_i  in  6  dart value 0..60, valid with dart_come_i.
- dart_double_i  in  1  dart landed in the double ring, valid with dart_come_i.
- game_set_o  out  1  game finished, winner decided.
- cur_player_o  out  1  active player: 0 = player 1, 1 = player 2.
- player_1_done_o / player_2_done_o  out  1  one-cycle pulse when that player's turn ends.
- player_1_win_o / player_2_win_o  out  1  winner flag, held until next new game.
- player_1_pt_o / player_2_pt_o  out  9  remaining points.

## Operation
- States: IDLE, THROW, CHECK, SWITCH, OVER.
- Reset values:
  - State is IDLE.
  - Both pt outputs are START_PT.
  - All other outputs are 0.
  - dart_cnt = 0; turn_start_pt = START_PT.
- IDLE: wait for new_game_i.
- new_game_i in any state, taking priority over dart_come_i:
  - Loads both pts with START_PT.
  - Clears win flags and game_set_o.
  - Sets cur = 0, dart_cnt = 0, turn_start_pt = START_PT.
  - Goes to THROW.
- THROW: on dart_come_i, latch score and double, then go to CHECK. A score > 60 is latched as 0 (miss).
- CHECK: compute rem = pt[cur] − score in 10-bit signed arithmetic. Outcomes, in priority order:
  - Bust (rem < 0): restore pt[cur] to turn_start_pt and go to SWITCH.
  - Win (rem == 0): pt[cur] = 0, set win[cur] and game_set_o, go to OVER.
  - Otherwise: pt[cur] = rem and dart_cnt++. Go to SWITCH if dart_cnt was DARTS_PER_TURN−1, else to THROW.
- SWITCH (one cycle):
  - Pulse done[cur].
  - Toggle cur; dart_cnt = 0.
  - Set turn_start_pt = pt of the new player.
  - Go to THROW.
- OVER: hold all outputs; leave only via new_game_i or reset.
- dart_come_i is ignored (dart dropped, no side effect) in IDLE, CHECK, SWITCH and OVER.
- Reset asserted mid-game returns to the reset values asynchronously; the game is lost.

## Timing
- All outputs are registered.
- dart_come_i sampled at edge k, in THROW:
  - CHECK occupies cycle k..k+1.
  - pt output is updated at edge k+2.
  - win/game_set_o are updated at edge k+2.
- Turn-ending dart at edge k: done pulse is high from edge k+2 to k+3, and cur_player_o toggles at k+2.
- Minimum dart spacing:
  - 2 cycles within a turn.
  - 3 cycles across a turn boundary.
  - The 3-cycle (60 ns) source spacing is always safe.
- new_game_i at edge k: outputs reset at edge k+1; a dart is accepted from edge k+1.

## Configuration
- DART_DOUBLE_OUT_EN defined, double-out rules apply:
  - Win requires rem == 0 with dart_double_i.
  - rem == 0 without a double is a bust.
  - rem == 1 is a bust.
- DART_DOUBLE_OUT_EN undefined: dart_double_i is ignored, and rem == 0 wins.

## Structure
- Shared package dart_pkg holds:
  - State enum.
  - PT_W = 9.
  - SCORE_W = 6.
  - MAX_DART_SCORE = 60.
  - Default START_PT.
- Sub-module dart_score_check, combinational:
  - Inputs: pt, score, double.
  - Outputs: rem, bust, win.
  - The DART_DOUBLE_OUT_EN logic lives here.

## Test plan
- Reset low then high:
  - Both pts 301.
  - All flags 0.
  - dart_come_i in IDLE is ignored.
- Normal turn: new_game; P1 throws 20, 20, 20 at 3-cycle spacing.
  - p1_pt ends at 241.
  - One player_1_done pulse 2 cycles after the 3rd dart.
  - cur_player = 1.
- Bust: P1 at 41 throws 20, then 30.
  - p1_pt restored to 41.
  - Turn passes immediately with a done pulse.
- Win: P2 at 40 throws double-20 (score 40, double = 1).
  - player_2_win_o = 1 and game_set_o = 1.
  - Later darts are ignored.
- Double-out (macro defined): P1 at 40 throws single 40 → bust, restored to 40. Undefined macro → same dart wins.
- Restart: new_game_i mid-turn, and a dart at edge k+1 → accepted and counted from START_PT; reset low mid-CHECK → pts 301 immediately.

Source files
------------

// File: rtl/dart_pkg.sv
// dart_pkg: shared widths, limits and FSM state encoding for the dart game controller.
package dart_pkg;
   localparam int PT_W           = 9;
   localparam int SCORE_W        = 6;
   localparam int MAX_DART_SCORE = 60;
   localparam int START_PT_DEF   = 301;
   typedef enum logic [2:0] {IDLE, THROW, CHECK, SWITCH, OVER} state_e;
endpackage

// File: rtl/dart_score_check.sv
// dart_score_check: remaining-points, bust and win evaluation for one dart.
// DART_DOUBLE_OUT_EN selects the double-out finishing rule.
module dart_score_check
   import dart_pkg::*;
(
   input  logic [PT_W-1:0]    pt,
   input  logic [SCORE_W-1:0] score,
   input  logic               dbl,
   output logic [PT_W-1:0]    rem,
   output logic               bust,
   output logic               win
);
   logic signed [PT_W:0] diff;
   assign diff = $signed({1'b0, pt}) - $signed({{(PT_W+1-SCORE_W){1'b0}}, score});
   assign rem  = diff[PT_W-1:0];
`ifdef DART_DOUBLE_OUT_EN
   // Leaving 1 point is unfinishable with a double, so it busts too.
   assign bust = diff[PT_W] || diff == 1 || (diff == 0 && !dbl);
   assign win  = diff == 0 && dbl;
`else
   logic unused_dbl;
   assign unused_dbl = dbl;
   assign bust = diff[PT_W];
   assign win  = diff == 0;
`endif
endmodule

// File: rtl/dart_game_ctrl.sv
// dart_game_ctrl: two-player countdown dart game sequencer (turns, bust, win).
// Double-out finishing is enabled by defining DART_DOUBLE_OUT_EN.
module dart_game_ctrl
   import dart_pkg::*;
#(
   parameter int START_PT       = START_PT_DEF,
   parameter int DARTS_PER_TURN = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               new_game_i,
   input  logic               dart_come_i,
   input  logic [SCORE_W-1:0] dart_score_i,
   input  logic               dart_double_i,
   output logic               game_set_o,
   output logic               cur_player_o,
   output logic               player_1_done_o,
   output logic               player_2_done_o,
   output logic               player_1_win_o,
   output logic               player_2_win_o,
   output logic [PT_W-1:0]    player_1_pt_o,
   output logic [PT_W-1:0]    player_2_pt_o
);
   localparam logic [PT_W-1:0] START = PT_W'(START_PT);
   localparam logic [2:0]      LAST  = 3'(DARTS_PER_TURN - 1);

   state_e              state_q, state_d;
   logic                cur_q, cur_d, done1_q, done1_d, done2_q, done2_d;
   logic                win1_q, win1_d, win2_q, win2_d, set_q, set_d, dbl_q, dbl_d;
   logic [2:0]          cnt_q, cnt_d;
   logic [PT_W-1:0]     ts_q, ts_d, pt1_q, pt1_d, pt2_q, pt2_d;
   logic [SCORE_W-1:0]  score_q, score_d;
   logic [PT_W-1:0]     p1_out_q, p2_out_q, rem;
   logic                w1_out_q, w2_out_q, set_out_q, bust, win;

   dart_score_check u_chk (
      .pt    (cur_q ? pt2_q : pt1_q),
      .score (score_q),
      .dbl   (dbl_q),
      .rem   (rem),
      .bust  (bust),
      .win   (win)
   );

   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      cnt_d   = cnt_q;
      ts_d    = ts_q;
      pt1_d   = pt1_q;
      pt2_d   = pt2_q;
      win1_d  = win1_q;
      win2_d  = win2_q;
      set_d   = set_q;
      done1_d = 1'b0;
      done2_d = 1'b0;
      score_d = score_q;
      dbl_d   = dbl_q;
      if (new_game_i) begin
         state_d = THROW;
         cur_d   = 1'b0;
         cnt_d   = '0;
         ts_d    = START;
         pt1_d   = START;
         pt2_d   = START;
         win1_d  = 1'b0;
         win2_d  = 1'b0;
         set_d   = 1'b0;
      end else begin
         case (state_q)
            THROW: if (dart_come_i) begin
               score_d = dart_score_i > SCORE_W'(MAX_DART_SCORE) ? '0 : dart_score_i;
               dbl_d   = dart_double_i;
               state_d = CHECK;
            end
            CHECK: if (bust) begin
               pt1_d   = cur_q ? pt1_q : ts_q;
               pt2_d   = cur_q ? ts_q : pt2_q;
               state_d = SWITCH;
            end else if (win) begin
               pt1_d   = cur_q ? pt1_q : '0;
               pt2_d   = cur_q ? '0 : pt2_q;
               win1_d  = !cur_q;
               win2_d  = cur_q;
               set_d   = 1'b1;
               state_d = OVER;
            end else begin
               pt1_d   = cur_q ? pt1_q : rem;
               pt2_d   = cur_q ? rem : pt2_q;
               cnt_d   = cnt_q + 3'd1;
               state_d = cnt_q == LAST ? SWITCH : THROW;
            end
            SWITCH: begin
               done1_d = !cur_q;
               done2_d = cur_q;
               cur_d   = !cur_q;
               cnt_d   = '0;
               ts_d    = cur_q ? pt1_q : pt2_q;
               state_d = THROW;
            end
            default: ;
         endcase
      end
   end

   // Points and win flags are presented one register stage after the game state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         cur_q     <= 1'b0;
         cnt_q     <= '0;
         ts_q      <= START;
         pt1_q     <= START;
         pt2_q     <= START;
         win1_q    <= 1'b0;
         win2_q    <= 1'b0;
         set_q     <= 1'b0;
         done1_q   <= 1'b0;
         done2_q   <= 1'b0;
         score_q   <= '0;
         dbl_q     <= 1'b0;
         p1_out_q  <= START;
         p2_out_q  <= START;
         w1_out_q  <= 1'b0;
         w2_out_q  <= 1'b0;
         set_out_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cur_q     <= cur_d;
         cnt_q     <= cnt_d;
         ts_q      <= ts_d;
         pt1_q     <= pt1_d;
         pt2_q     <= pt2_d;
         win1_q    <= win1_d;
         win2_q    <= win2_d;
         set_q     <= set_d;
         done1_q   <= done1_d;
         done2_q   <= done2_d;
         score_q   <= score_d;
         dbl_q     <= dbl_d;
         p1_out_q  <= pt1_q;
         p2_out_q  <= pt2_q;
         w1_out_q  <= win1_q;
         w2_out_q  <= win2_q;
         set_out_q <= set_q;
      end
   end

   assign game_set_o      = set_out_q;
   assign cur_player_o    = cur_q;
   assign player_1_done_o = done1_q;
   assign player_2_done_o = done2_q;
   assign player_1_win_o  = w1_out_q;
   assign player_2_win_o  = w2_out_q;
   assign player_1_pt_o   = p1_out_q;
   assign player_2_pt_o   = p2_out_q;
endmodule

// File: tb/tb_dart_game_ctrl.sv
// tb_dart_game_ctrl: table vectors, corner sequences and a randomized game model for dart_game_ctrl.
module tb_dart_game_ctrl;
   localparam int START = 301;
   localparam int DPT   = 3;
`ifdef DART_DOUBLE_OUT_EN
   localparam bit DO = 1'b1;
`else
   localparam bit DO = 1'b0;
`endif

   typedef struct {
      logic [8:0] p1, p2;
      logic       cur, d1, d2, w1, w2, set;
   } exp_t;
   typedef struct {
      int   s;
      bit   d;
      exp_t e;
   } vec_t;

   logic       clk = 1'b0, reset = 1'b1, new_game_i = 1'b0, dart_come_i = 1'b0, dart_double_i = 1'b0;
   logic [5:0] dart_score_i = '0;
   logic       game_set_o, cur_player_o, player_1_done_o, player_2_done_o, player_1_win_o, player_2_win_o;
   logic [8:0] player_1_pt_o, player_2_pt_o;

   int   checks = 0, errors = 0;
   exp_t cur_e;
   vec_t tv[22];

   int   m_pt[2], m_cur, m_nd, m_start;
   bit   m_win[2], m_over, m_active;

   dart_game_ctrl dut (
      .clk             (clk),
      .reset           (reset),
      .new_game_i      (new_game_i),
      .dart_come_i     (dart_come_i),
      .dart_score_i    (dart_score_i),
      .dart_double_i   (dart_double_i),
      .game_set_o      (game_set_o),
      .cur_player_o    (cur_player_o),
      .player_1_done_o (player_1_done_o),
      .player_2_done_o (player_2_done_o),
      .player_1_win_o  (player_1_win_o),
      .player_2_win_o  (player_2_win_o),
      .player_1_pt_o   (player_1_pt_o),
      .player_2_pt_o   (player_2_pt_o)
   );

   always #10 clk = ~clk;

   function automatic exp_t mk(int p1, int p2, bit c, bit d1, bit d2, bit w1, bit w2, bit s);
      exp_t e;
      e.p1 = 9'(p1);
      e.p2 = 9'(p2);
      e.cur = c;
      e.d1 = d1;
      e.d2 = d2;
      e.w1 = w1;
      e.w2 = w2;
      e.set = s;
      return e;
   endfunction

   task automatic check(input string tag, input string f, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s.%s got %0d expected %0d at %0t", tag, f, got, exp, $time);
      end
   endtask

   task automatic compare_all(input exp_t e, input string tag);
      check(tag, "p1_pt", int'(player_1_pt_o), int'(e.p1));
      check(tag, "p2_pt", int'(player_2_pt_o), int'(e.p2));
      check(tag, "cur", int'(cur_player_o), int'(e.cur));
      check(tag, "done1", int'(player_1_done_o), int'(e.d1));
      check(tag, "done2", int'(player_2_done_o), int'(e.d2));
      check(tag, "win1", int'(player_1_win_o), int'(e.w1));
      check(tag, "win2", int'(player_2_win_o), int'(e.w2));
      check(tag, "set", int'(game_set_o), int'(e.set));
   endtask

   // Called at a negedge; dart sampled at edge k, results compared after edge k+2.
   task automatic throw(input int s, input bit d, input exp_t nxt, input string tag);
      exp_t pre;
      pre = cur_e;
      pre.d1 = 1'b0;
      pre.d2 = 1'b0;
      dart_come_i = 1'b1;
      dart_score_i = 6'(s);
      dart_double_i = d;
      @(negedge clk);
      dart_come_i = 1'b0;
      dart_double_i = 1'b0;
      compare_all(pre, {tag, "@k"});
      @(negedge clk);
      compare_all(pre, {tag, "@k+1"});
      @(negedge clk);
      compare_all(nxt, {tag, "@k+2"});
      cur_e = nxt;
   endtask

   task automatic new_game();
      new_game_i = 1'b1;
      @(negedge clk);
      new_game_i = 1'b0;
      cur_e = mk(START, START, 0, 0, 0, 0, 0, 0);
      m_pt[0] = START;
      m_pt[1] = START;
      m_cur = 0;
      m_nd = 0;
      m_start = START;
      m_win[0] = 0;
      m_win[1] = 0;
      m_over = 0;
      m_active = 1;
   endtask

   // Game-rule reference: applies one dart to the abstract game and returns the expected outputs.
   task automatic m_dart(input int s_in, input bit d, output exp_t e);
      int  s, r, who;
      bit  ended;
      s = s_in > 60 ? 0 : s_in;
      ended = 0;
      who = m_cur;
      if (m_active && !m_over) begin
         r = m_pt[m_cur] - s;
         if (r < 0 || (DO && (r == 1 || (r == 0 && !d)))) begin
            m_pt[m_cur] = m_start;
            ended = 1;
         end else if (r == 0) begin
            m_pt[m_cur] = 0;
            m_win[m_cur] = 1;
            m_over = 1;
         end else begin
            m_pt[m_cur] = r;
            m_nd++;
            ended = m_nd == DPT;
         end
         if (ended) begin
            m_cur ^= 1;
            m_nd = 0;
            m_start = m_pt[m_cur];
         end
      end
      e = mk(m_pt[0], m_pt[1], m_cur[0], ended && who == 0, ended && who == 1, m_win[0], m_win[1], m_over);
   endtask

   initial begin
      exp_t e;
      tv[0]  = '{20, 0, mk(281, 301, 0, 0, 0, 0, 0, 0)};
      tv[1]  = '{20, 0, mk(261, 301, 0, 0, 0, 0, 0, 0)};
      tv[2]  = '{20, 0, mk(241, 301, 1, 1, 0, 0, 0, 0)};
      tv[3]  = '{60, 0, mk(241, 241, 1, 0, 0, 0, 0, 0)};
      tv[4]  = '{60, 1, mk(241, 181, 1, 0, 0, 0, 0, 0)};
      tv[5]  = '{60, 0, mk(241, 121, 0, 0, 1, 0, 0, 0)};
      tv[6]  = '{63, 0, mk(241, 121, 0, 0, 0, 0, 0, 0)};
      tv[7]  = '{60, 0, mk(181, 121, 0, 0, 0, 0, 0, 0)};
      tv[8]  = '{60, 0, mk(121, 121, 1, 1, 0, 0, 0, 0)};
      tv[9]  = '{60, 0, mk(121, 61, 1, 0, 0, 0, 0, 0)};
      tv[10] = '{21, 0, mk(121, 40, 1, 0, 0, 0, 0, 0)};
      tv[11] = '{0, 0, mk(121, 40, 0, 0, 1, 0, 0, 0)};
      tv[12] = '{60, 0, mk(61, 40, 0, 0, 0, 0, 0, 0)};
      tv[13] = '{20, 0, mk(41, 40, 0, 0, 0, 0, 0, 0)};
      tv[14] = '{0, 0, mk(41, 40, 1, 1, 0, 0, 0, 0)};
      tv[15] = '{0, 0, mk(41, 40, 1, 0, 0, 0, 0, 0)};
      tv[16] = '{0, 0, mk(41, 40, 1, 0, 0, 0, 0, 0)};
      tv[17] = '{0, 0, mk(41, 40, 0, 0, 1, 0, 0, 0)};
      tv[18] = '{20, 0, mk(21, 40, 0, 0, 0, 0, 0, 0)};
      tv[19] = '{30, 0, mk(41, 40, 1, 1, 0, 0, 0, 0)};
      tv[20] = '{40, 1, mk(41, 0, 1, 0, 0, 0, 1, 1)};
      tv[21] = '{20, 0, mk(41, 0, 1, 0, 0, 0, 1, 1)};

      #5 reset = 1'b0;
      #10 compare_all(mk(START, START, 0, 0, 0, 0, 0, 0), "reset");
      @(negedge clk);
      reset = 1'b1;
      m_active = 0;
      cur_e = mk(START, START, 0, 0, 0, 0, 0, 0);
      throw(20, 0, cur_e, "idle_dart");

      new_game();
      foreach (tv[i]) throw(tv[i].s, tv[i].d, tv[i].e, $sformatf("vec%0d", i));

      // Restart after a win with a dart right on the edge after new_game.
      new_game();
      throw(20, 0, mk(281, 301, 0, 0, 0, 0, 0, 0), "restart_win");
      throw(60, 0, mk(221, 301, 0, 0, 0, 0, 0, 0), "mid_turn");
      new_game();
      throw(20, 0, mk(281, 301, 0, 0, 0, 0, 0, 0), "restart_mid");

      // Asynchronous reset while the dart is being checked.
      dart_come_i = 1'b1;
      dart_score_i = 6'd20;
      @(negedge clk);
      dart_come_i = 1'b0;
      #3 reset = 1'b0;
      #1 compare_all(mk(START, START, 0, 0, 0, 0, 0, 0), "reset_check");
      @(negedge clk);
      reset = 1'b1;
      m_active = 0;
      cur_e = mk(START, START, 0, 0, 0, 0, 0, 0);
      throw(40, 1, cur_e, "post_reset_idle");

      // Single 40 on exactly 40 left: bust under double-out, win otherwise.
      new_game();
      throw(60, 0, mk(241, 301, 0, 0, 0, 0, 0, 0), "do1");
      throw(60, 0, mk(181, 301, 0, 0, 0, 0, 0, 0), "do2");
      throw(60, 0, mk(121, 301, 1, 1, 0, 0, 0, 0), "do3");
      for (int i = 0; i < 3; i++) throw(0, 0, mk(121, 301, i == 2 ? 0 : 1, 0, i == 2, 0, 0, 0), "do_p2");
      throw(60, 0, mk(61, 301, 0, 0, 0, 0, 0, 0), "do4");
      throw(21, 0, mk(40, 301, 0, 0, 0, 0, 0, 0), "do5");
      throw(0, 0, mk(40, 301, 1, 1, 0, 0, 0, 0), "do6");
      for (int i = 0; i < 3; i++) throw(0, 0, mk(40, 301, i == 2 ? 0 : 1, 0, i == 2, 0, 0, 0), "do_p2b");
`ifdef DART_DOUBLE_OUT_EN
      throw(40, 0, mk(40, 301, 1, 1, 0, 0, 0, 0), "double_out");
`else
      throw(40, 0, mk(0, 301, 0, 0, 0, 1, 0, 1), "double_out");
`endif

      for (int g = 0; g < 16; g++) begin
         new_game();
         for (int n = 0; n < 50; n++) begin
            int s;
            bit d;
            s = $urandom_range(0, 3) == 0 ? (m_pt[m_cur] > 60 ? 60 : m_pt[m_cur]) : int'($urandom_range(0, 63));
            d = 1'($urandom_range(0, 1));
            m_dart(s, d, e);
            throw(s, d, e, $sformatf("rand%0d_%0d", g, n));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
